bg_scroll_ctrl: RTL and testbench
=================================

Name: bg_scroll_ctrl

Overview:
Frame-synchronous scroll and scene controller for the background pixel renderers.
- Accepts host register writes into shadow registers and commits them atomically at the next vsync rising edge.
- Runs a fixed-point scroll accumulator, advanced once per frame, that drives the renderer's scroll offset and enable.
- Replaces the vsync-clocked free-running counter; all logic runs on the pixel clock domain.

Parameters:
H_RES, 1024, horizontal wrap modulus in pixels (640 or 1024)
FRAC_W, 4, fractional bits of scroll position and speed
SPEED_W, 8, speed register width, unsigned fixed point (SPEED_W-FRAC_W).FRAC_W pixels/frame

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
vsync  in  1  vertical sync level from timing generator, clk domain
cfg_we  in  1  register write strobe, single cycle
cfg_addr  in  2  0=CTRL, 1=SPEED, 2=LOAD_LO, 3=LOAD_HI
cfg_wdata  in  8  write data
pending  out  1  shadow holds uncommitted writes
commit_pulse  out  1  one-cycle pulse when shadow is committed
frame_pulse  out  1  one-cycle pulse when scroll_x has been updated
bg_en  out  1  committed enable to renderer
scroll_x  out  10  integer scroll offset, 0..H_RES-1
parallax_x  out  10  half-rate scroll offset (see Optional Feature)
state  out  2  0=OFF, 1=RUN, 2=PAUSED

Behaviour:
- Reset values: all outputs, shadow registers, active registers and accumulators are 0; state is OFF.
- Registers:
  - CTRL: bit0 enable, bit1 dir (0 = increasing), bit2 pause, bit3 step. Step is self-clearing after commit.
  - SPEED: pixels/frame in 4.4 format.
  - LOAD_LO: load[7:0].
  - LOAD_HI: bits[1:0] are load[9:8]; bit7 is load_req, self-clearing after commit.
- Any write sets pending=1 and updates the shadow copy only.
- Frame edge E: the cycle in which vsync=1 and registered vsync_q=0.
- At the end of cycle E, if pending:
  - active <= shadow, pending <= 0, commit_pulse=1 in E+1.
  - Shadow step and load_req clear.
- A cfg_we in cycle E is written to shadow but excluded from this commit; pending stays 1 and the write commits at the next frame.
- State transitions, evaluated in E+1 from active CTRL:
  - enable=0 -> OFF.
  - enable=1, pause=0 -> RUN.
  - enable=1, pause=1 -> PAUSED.
- Position update at the end of E+1:
  - If active load_req was committed this frame: scroll_x <= load mod H_RES, frac <= 0; no advance this frame, in any state except OFF.
  - Else in RUN, or in PAUSED with step committed this frame: pos = {scroll_x, frac} ± speed, per dir.
  - OFF and PAUSED without step: pos holds.
- frame_pulse=1 in cycle E+2 whenever state != OFF.
- Latency: scroll_x is valid 2 cycles after the vsync rise.
- Arithmetic:
  - Positions are 10+FRAC_W bits with modulus M = H_RES<<FRAC_W.
  - Increasing: sum >= M -> subtract M.
  - Decreasing: borrow -> add M.
  - One correction suffices because max speed is below H_RES.
- bg_en = active enable, registered.
- vsync held high does not retrigger; glitch-free edge only.
- rst asserted mid-frame: immediate return to reset values; the first commit happens at the next E after release.

Optional Feature:
Macro BG_SCROLL_PARALLAX_EN.
- Defined: a second accumulator advances by speed>>1 (same dir, step, load, wrap rules); load sets it to load>>1. parallax_x is its integer part.
- Undefined: no second accumulator; parallax_x tied to 0.

Decomposition:
- Package bg_ctrl_pkg holds:
  - register address constants and CTRL/LOAD_HI bit positions;
  - state encoding (OFF/RUN/PAUSED);
  - FRAC_W default and the H_RES choices 640/1024.
- Sub-module bg_frame_tick: registers vsync and emits the single-cycle edge E. It is reused by other frame-synchronous controllers.

Test Plan:
- SPEED=0x10, CTRL=0x01, 3 vsync rises -> scroll_x 1,2,3; frame_pulse once per frame; commit_pulse only on the first.
- H_RES=640, LOAD=639 with load_req, SPEED=0x20 -> frame1 scroll_x=639, frame2 scroll_x=1 (wrap).
- H_RES=640, LOAD=0, CTRL=0x03 (dir=1), SPEED=0x18 -> frame2 scroll_x=638, frac=8.
- RUN at 10, CTRL=0x05 (pause) -> holds 10 for 4 frames; CTRL=0x0D (step) -> 11 once, then holds; state=2.
- Write SPEED=0x30 in exactly cycle E -> pending stays 1, no change this frame; +3/frame from the following frame.
- rst pulsed mid-frame while RUN at 200 -> scroll_x=0, bg_en=0, state=0, pending=0 immediately; no frame_pulse afterwards until enabled.

Source files
------------

// File: rtl/bg_ctrl_pkg.sv
// Shared constants for the background scroll/scene controllers: register map,
// CTRL/LOAD_HI bit positions, state encoding and supported wrap widths.
package bg_ctrl_pkg;

  // Host register addresses
  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrSpeed  = 2'd1;
  localparam logic [1:0] AddrLoadLo = 2'd2;
  localparam logic [1:0] AddrLoadHi = 2'd3;

  // CTRL bit positions
  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlDirBit   = 1;
  localparam int unsigned CtrlPauseBit = 2;
  localparam int unsigned CtrlStepBit  = 3;

  // LOAD_HI request bit
  localparam int unsigned LoadReqBit = 7;

  // Geometry defaults
  localparam int unsigned FracWDefault = 4;
  localparam int unsigned HRes640      = 640;
  localparam int unsigned HRes1024     = 1024;

  typedef enum logic [1:0] {
    StOff    = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2
  } bg_state_e;

  // Scroll state implied by a committed CTRL value
  function automatic bg_state_e ctrl_state(input logic en, input logic pause);
    if (!en) begin
      return StOff;
    end else if (pause) begin
      return StPaused;
    end else begin
      return StRun;
    end
  endfunction

endpackage

// File: rtl/bg_frame_tick.sv
// Frame edge detector: registers vsync and flags the single cycle in which
// vsync is high but was low in the previous cycle.
module bg_frame_tick (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vsync_i,
  output logic frame_edge_o
);

  logic vsync_d, vsync_q;

  // Next-state is simply the current vsync level
  always_comb begin
    vsync_d = vsync_i;
  end

  // Delayed copy of vsync
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync_d;
    end
  end

  assign frame_edge_o = vsync_i & ~vsync_q;

endmodule

// File: rtl/bg_scroll_ctrl.sv
// Frame-synchronous scroll and scene controller. Host writes land in shadow
// registers and are committed together at the next vsync rise; a fixed-point
// accumulator then advances the scroll position once per frame.
// Optional half-rate parallax accumulator: define BG_SCROLL_PARALLAX_EN.
module bg_scroll_ctrl
  import bg_ctrl_pkg::*;
#(
  parameter int unsigned H_RES   = HRes1024,
  parameter int unsigned FRAC_W  = FracWDefault,
  parameter int unsigned SPEED_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic       pending,
  output logic       commit_pulse,
  output logic       frame_pulse,
  output logic       bg_en,
  output logic [9:0] scroll_x,
  output logic [9:0] parallax_x,
  output logic [1:0] state
);

  localparam int unsigned PW = 10 + FRAC_W;
  localparam logic [PW:0] Mod = (PW+1)'(H_RES << FRAC_W);

  logic frame_edge;

  bg_frame_tick u_frame_tick (
    .clk_i        (clk),
    .rst_i        (rst),
    .vsync_i      (vsync),
    .frame_edge_o (frame_edge)
  );

  // Shadow and active register banks
  logic [3:0]         sh_ctrl_d, sh_ctrl_q, act_ctrl_d, act_ctrl_q;
  logic [SPEED_W-1:0] sh_speed_d, sh_speed_q, act_speed_d, act_speed_q;
  logic [9:0]         sh_load_d, sh_load_q, act_load_d, act_load_q;
  logic               sh_load_req_d, sh_load_req_q, act_load_req_d, act_load_req_q;
  logic               pending_d, pending_q;
  logic               commit_d, commit_q;
  logic               tick_d, tick_q;  // high in E+1

  // Frame-domain state
  bg_state_e          state_d, state_q;
  logic [PW-1:0]      pos_d, pos_q;
  logic               frame_d, frame_q;
  logic               bg_en_d, bg_en_q;

  // One modular step of a {int, frac} position; one correction is enough
  // because speed never reaches a full wrap.
  function automatic logic [PW-1:0] step_pos(input logic [PW-1:0] pos,
                                             input logic [PW-1:0] spd,
                                             input logic          dir);
    logic [PW:0] acc;
    if (!dir) begin
      acc = {1'b0, pos} + {1'b0, spd};
      if (acc >= Mod) acc = acc - Mod;
    end else begin
      acc = {1'b0, pos} - {1'b0, spd};
      if (acc[PW]) acc = acc + Mod;
    end
    return acc[PW-1:0];
  endfunction

  // Commit on the frame edge first, then apply any same-cycle host write so it
  // stays in the shadow for the following frame.
  always_comb begin
    sh_ctrl_d      = sh_ctrl_q;
    sh_speed_d     = sh_speed_q;
    sh_load_d      = sh_load_q;
    sh_load_req_d  = sh_load_req_q;
    act_ctrl_d     = act_ctrl_q;
    act_speed_d    = act_speed_q;
    act_load_d     = act_load_q;
    act_load_req_d = act_load_req_q;
    pending_d      = pending_q;
    commit_d       = 1'b0;
    tick_d         = frame_edge;

    if (frame_edge && pending_q) begin
      act_ctrl_d               = sh_ctrl_q;
      act_speed_d              = sh_speed_q;
      act_load_d               = sh_load_q;
      act_load_req_d           = sh_load_req_q;
      pending_d                = 1'b0;
      commit_d                 = 1'b1;
      sh_ctrl_d[CtrlStepBit]   = 1'b0;
      sh_load_req_d            = 1'b0;
    end

    if (cfg_we) begin
      pending_d = 1'b1;
      case (cfg_addr)
        AddrCtrl:   sh_ctrl_d = cfg_wdata[3:0];
        AddrSpeed:  sh_speed_d = cfg_wdata[SPEED_W-1:0];
        AddrLoadLo: sh_load_d[7:0] = cfg_wdata;
        default: begin
          sh_load_d[9:8] = cfg_wdata[1:0];
          sh_load_req_d  = cfg_wdata[LoadReqBit];
        end
      endcase
    end
  end

  logic            do_load, do_step, advance;
  bg_state_e       nxt_state;
  logic [9:0]      load_mod;

  // Per-frame state and position update, evaluated in E+1
  always_comb begin
    nxt_state = ctrl_state(act_ctrl_q[CtrlEnBit], act_ctrl_q[CtrlPauseBit]);
    do_load   = commit_q & act_load_req_q & (nxt_state != StOff);
    do_step   = commit_q & act_ctrl_q[CtrlStepBit];
    advance   = (nxt_state == StRun) || ((nxt_state == StPaused) && do_step);
    if ({1'b0, act_load_q} >= 11'(H_RES)) begin
      load_mod = 10'({1'b0, act_load_q} - 11'(H_RES));
    end else begin
      load_mod = act_load_q;
    end

    state_d = state_q;
    pos_d   = pos_q;
    frame_d = 1'b0;
    bg_en_d = act_ctrl_q[CtrlEnBit];
    if (tick_q) begin
      state_d = nxt_state;
      frame_d = (nxt_state != StOff);
      if (do_load) begin
        pos_d = {load_mod, {FRAC_W{1'b0}}};
      end else if (advance) begin
        pos_d = step_pos(pos_q, PW'(act_speed_q), act_ctrl_q[CtrlDirBit]);
      end
    end
  end

  // All controller state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_ctrl_q      <= '0;
      sh_speed_q     <= '0;
      sh_load_q      <= '0;
      sh_load_req_q  <= 1'b0;
      act_ctrl_q     <= '0;
      act_speed_q    <= '0;
      act_load_q     <= '0;
      act_load_req_q <= 1'b0;
      pending_q      <= 1'b0;
      commit_q       <= 1'b0;
      tick_q         <= 1'b0;
      state_q        <= StOff;
      pos_q          <= '0;
      frame_q        <= 1'b0;
      bg_en_q        <= 1'b0;
    end else begin
      sh_ctrl_q      <= sh_ctrl_d;
      sh_speed_q     <= sh_speed_d;
      sh_load_q      <= sh_load_d;
      sh_load_req_q  <= sh_load_req_d;
      act_ctrl_q     <= act_ctrl_d;
      act_speed_q    <= act_speed_d;
      act_load_q     <= act_load_d;
      act_load_req_q <= act_load_req_d;
      pending_q      <= pending_d;
      commit_q       <= commit_d;
      tick_q         <= tick_d;
      state_q        <= state_d;
      pos_q          <= pos_d;
      frame_q        <= frame_d;
      bg_en_q        <= bg_en_d;
    end
  end

`ifdef BG_SCROLL_PARALLAX_EN
  logic [PW-1:0] par_pos_d, par_pos_q;

  // Half-speed accumulator sharing the main load/step/wrap rules
  always_comb begin
    par_pos_d = par_pos_q;
    if (tick_q) begin
      if (do_load) begin
        par_pos_d = {1'b0, act_load_q[9:1], {FRAC_W{1'b0}}};
      end else if (advance) begin
        par_pos_d = step_pos(par_pos_q, PW'(act_speed_q >> 1), act_ctrl_q[CtrlDirBit]);
      end
    end
  end

  // Parallax position register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_pos_q <= '0;
    end else begin
      par_pos_q <= par_pos_d;
    end
  end

  assign parallax_x = par_pos_q[PW-1:FRAC_W];
`else
  assign parallax_x = '0;
`endif

  assign pending      = pending_q;
  assign commit_pulse = commit_q;
  assign frame_pulse  = frame_q;
  assign bg_en        = bg_en_q;
  assign scroll_x     = pos_q[PW-1:FRAC_W];
  assign state        = state_q;

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// Directed bench for bg_scroll_ctrl at H_RES=640: a table of per-frame
// register writes with expected results, plus hand-written sequences for a
// write landing in the frame-edge cycle and a mid-frame reset.
module tb_bg_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       pending, commit_pulse, frame_pulse, bg_en;
  logic [9:0] scroll_x, parallax_x;
  logic [1:0] state;

  bg_scroll_ctrl #(
    .H_RES   (640),
    .FRAC_W  (4),
    .SPEED_W (8)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .vsync        (vsync),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .pending      (pending),
    .commit_pulse (commit_pulse),
    .frame_pulse  (frame_pulse),
    .bg_en        (bg_en),
    .scroll_x     (scroll_x),
    .parallax_x   (parallax_x),
    .state        (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_commit = 0;
  int n_frame  = 0;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (commit_pulse) n_commit <= n_commit + 1;
    if (frame_pulse)  n_frame  <= n_frame + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Finish a frame after E+2: hold vsync high a while, drop it, idle
  task automatic frame_tail();
    repeat (4) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [2:0]       nw;
    logic [3:0][9:0]  w;       // {addr, data}
    logic [9:0]       exp_x;
    logic [1:0]       exp_st;
    logic [1:0]       exp_commit;
    logic [1:0]       exp_frame;
  } vec_t;

  function automatic vec_t mk(input int nw, input logic [9:0] w0, input logic [9:0] w1,
                              input logic [9:0] w2, input logic [9:0] w3, input int x,
                              input int st, input int c, input int f);
    vec_t v;
    v.nw = 3'(nw); v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.exp_x = 10'(x); v.exp_st = 2'(st); v.exp_commit = 2'(c); v.exp_frame = 2'(f);
    return v;
  endfunction

  localparam int NV = 19;
  vec_t vecs [NV];

  initial begin
    int c0, f0;
    vec_t v;

    // 0=CTRL 1=SPEED 2=LOAD_LO 3=LOAD_HI
    vecs[0]  = mk(2, {2'd1, 8'h10}, {2'd0, 8'h01}, '0, '0, 1, 1, 1, 1);
    vecs[1]  = mk(0, '0, '0, '0, '0, 2, 1, 0, 1);
    vecs[2]  = mk(0, '0, '0, '0, '0, 3, 1, 0, 1);
    vecs[3]  = mk(2, {2'd2, 8'd10}, {2'd3, 8'h80}, '0, '0, 10, 1, 1, 1);
    vecs[4]  = mk(1, {2'd0, 8'h05}, '0, '0, '0, 10, 2, 1, 1);
    vecs[5]  = mk(0, '0, '0, '0, '0, 10, 2, 0, 1);
    vecs[6]  = mk(0, '0, '0, '0, '0, 10, 2, 0, 1);
    vecs[7]  = mk(0, '0, '0, '0, '0, 10, 2, 0, 1);
    vecs[8]  = mk(1, {2'd0, 8'h0D}, '0, '0, '0, 11, 2, 1, 1);
    vecs[9]  = mk(0, '0, '0, '0, '0, 11, 2, 0, 1);
    vecs[10] = mk(4, {2'd1, 8'h20}, {2'd2, 8'h7F}, {2'd3, 8'h82}, {2'd0, 8'h01},
                  639, 1, 1, 1);
    vecs[11] = mk(0, '0, '0, '0, '0, 1, 1, 0, 1);
    vecs[12] = mk(4, {2'd2, 8'h00}, {2'd3, 8'h80}, {2'd0, 8'h03}, {2'd1, 8'h18},
                  0, 1, 1, 1);
    vecs[13] = mk(0, '0, '0, '0, '0, 638, 1, 0, 1);
    vecs[14] = mk(0, '0, '0, '0, '0, 637, 1, 0, 1);
    vecs[15] = mk(1, {2'd0, 8'h00}, '0, '0, '0, 637, 0, 1, 0);
    vecs[16] = mk(0, '0, '0, '0, '0, 637, 0, 0, 0);
    vecs[17] = mk(4, {2'd0, 8'h01}, {2'd1, 8'h10}, {2'd2, 8'hBC}, {2'd3, 8'h82},
                  60, 1, 1, 1);
    vecs[18] = mk(0, '0, '0, '0, '0, 61, 1, 0, 1);

    rst = 1'b1; vsync = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    check("reset scroll_x", int'(scroll_x), 0);
    check("reset state", int'(state), 0);
    check("reset bg_en", int'(bg_en), 0);
    check("reset pending", int'(pending), 0);
    check("reset commit_pulse", int'(commit_pulse), 0);
    check("reset frame_pulse", int'(frame_pulse), 0);
    check("reset parallax_x", int'(parallax_x), 0);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      for (int k = 0; k < int'(v.nw); k++) wr(v.w[k][9:8], v.w[k][7:0]);
      if (v.nw != 0) check($sformatf("v%0d pending before edge", i), int'(pending), 1);
      c0 = n_commit; f0 = n_frame;
      vsync = 1'b1;                    // cycle E
      repeat (2) @(posedge clk); #1;   // E+2
      check($sformatf("v%0d scroll_x", i), int'(scroll_x), int'(v.exp_x));
      check($sformatf("v%0d state", i), int'(state), int'(v.exp_st));
      check($sformatf("v%0d bg_en", i), int'(bg_en), (v.exp_st != 0) ? 1 : 0);
      check($sformatf("v%0d parallax_x", i), int'(parallax_x), 0);
      frame_tail();
      check($sformatf("v%0d commit count", i), n_commit - c0, int'(v.exp_commit));
      check($sformatf("v%0d frame count", i), n_frame - f0, int'(v.exp_frame));
      check($sformatf("v%0d pending after", i), int'(pending), 0);
    end

    // Write in exactly cycle E: excluded from this commit, lands next frame
    wr(2'd0, 8'h01);
    vsync = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 8'h30;
    @(posedge clk); #1 cfg_we = 1'b0;  // E+1
    check("edge-write commit_pulse", int'(commit_pulse), 1);
    check("edge-write pending held", int'(pending), 1);
    @(posedge clk); #1;
    check("edge-write old speed", int'(scroll_x), 62);
    frame_tail();
    vsync = 1'b1;
    @(posedge clk); #1;
    check("edge-write next commit", int'(commit_pulse), 1);
    @(posedge clk); #1;
    check("edge-write new speed", int'(scroll_x), 65);
    check("edge-write pending cleared", int'(pending), 0);
    frame_tail();
    vsync = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("edge-write speed 3 again", int'(scroll_x), 68);
    frame_tail();

    // Mid-frame reset while running at 200
    wr(2'd2, 8'hC8);
    wr(2'd3, 8'h80);
    vsync = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("load 200", int'(scroll_x), 200);
    frame_tail();
    wr(2'd1, 8'h10);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst scroll_x", int'(scroll_x), 0);
    check("rst bg_en", int'(bg_en), 0);
    check("rst state", int'(state), 0);
    check("rst pending", int'(pending), 0);
    @(posedge clk); #1 rst = 1'b0;
    c0 = n_commit; f0 = n_frame;
    for (int j = 0; j < 2; j++) begin
      vsync = 1'b1;
      repeat (2) @(posedge clk); #1;
      frame_tail();
    end
    check("post-rst frame pulses", n_frame - f0, 0);
    check("post-rst commit pulses", n_commit - c0, 0);
    check("post-rst scroll_x", int'(scroll_x), 0);
    check("post-rst state", int'(state), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
